// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard interface between the instruction decoder and the hazard scoreboard.
// master : decoder side, drives the decode-slot description and receives stall/forward/busy.
// slave  : scoreboard side.
// Signals:
//   d_valid           decode slot holds a real instruction
//   d_rs, d_rt        source register addresses
//   d_use_rs/rt       source is actually read
//   d_tuse_rs/rt      cycles until each source is consumed
//   d_wen, d_wdst     GRF write enable and resolved destination
//   d_tnew            cycles until the result exists, as seen in E
//   d_md_start        multiply/divide trigger
//   d_md_op           multiply/divide op, bit 1 selects divide
//   d_md_acc          instruction touches HI/LO
//   stall             freeze PC and F/D, bubble into E
//   fwd_rs, fwd_rt    0 = GRF, k = forward from tracked stage k
//   md_busy           multiply/divide unit still running
interface hazard_scoreboard_if #(
   parameter int unsigned AW = 5,
   parameter int unsigned TW = 2,
   parameter int unsigned SW = 2
);
   logic          d_valid;
   logic [AW-1:0] d_rs;
   logic [AW-1:0] d_rt;
   logic          d_use_rs;
   logic          d_use_rt;
   logic [TW-1:0] d_tuse_rs;
   logic [TW-1:0] d_tuse_rt;
   logic          d_wen;
   logic [AW-1:0] d_wdst;
   logic [TW-1:0] d_tnew;
   logic          d_md_start;
   logic [2:0]    d_md_op;
   logic          d_md_acc;
   logic          stall;
   logic [SW-1:0] fwd_rs;
   logic [SW-1:0] fwd_rt;
   logic          md_busy;

   modport master (
      output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
      output d_wen, d_wdst, d_tnew, d_md_start, d_md_op, d_md_acc,
      input  stall, fwd_rs, fwd_rt, md_busy
   );

   modport slave (
      input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
      input  d_wen, d_wdst, d_tnew, d_md_start, d_md_op, d_md_acc,
      output stall, fwd_rs, fwd_rt, md_busy
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard.
// Tracks {write enable, destination, Tnew} for each in-flight instruction in stages 1..NSTG
// after decode (1 = E), resolves decode-stage source hazards into a stall or a forward select,
// and owns the multiply/divide busy counter that holds off HI/LO accessors.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    hazard_scoreboard_if.slave (decode-slot inputs, stall/fwd_rs/fwd_rt/md_busy outputs)
module hazard_scoreboard #(
   parameter int unsigned NSTG    = 3,
   parameter int unsigned AW      = 5,
   parameter int unsigned TW      = 2,
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10,
   parameter int unsigned CW      = 4,
   parameter int unsigned SW      = $clog2(NSTG + 1)
) (
   input logic                clk,
   input logic                reset,
   hazard_scoreboard_if.slave bus
);

   // Stage 1 is the youngest tracked instruction (E); higher indices are older.
   logic [NSTG:1]         wen_q,  wen_d;
   logic [NSTG:1][AW-1:0] dst_q,  dst_d;
   logic [NSTG:1][TW-1:0] tnew_q, tnew_d;
   logic [CW-1:0]         cnt_q,  cnt_d;

   logic          hit_rs, hit_rt;
   logic [SW-1:0] idx_rs, idx_rt;
   logic [TW-1:0] tn_rs,  tn_rt;
   logic          dstall_rs, dstall_rt, md_busy, md_stall, stall;

   // Only op[1] matters here; the rest of the op is the multiplier's business.
   logic unused_md_op;
   assign unused_md_op = ^{bus.d_md_op[2], bus.d_md_op[0]};

   // Scan from oldest to youngest so the youngest matching entry wins (shadowing).
   always_comb begin : match
      hit_rs = 1'b0;
      idx_rs = '0;
      tn_rs  = '0;
      hit_rt = 1'b0;
      idx_rt = '0;
      tn_rt  = '0;
      for (int k = NSTG; k >= 1; k--) begin
         if (wen_q[k] && (dst_q[k] == bus.d_rs)) begin
            hit_rs = 1'b1;
            idx_rs = SW'(k);
            tn_rs  = tnew_q[k];
         end
         if (wen_q[k] && (dst_q[k] == bus.d_rt)) begin
            hit_rt = 1'b1;
            idx_rt = SW'(k);
            tn_rt  = tnew_q[k];
         end
      end
      // $0 is never a real dependency, and an unread source cannot cause a hazard.
      if (!bus.d_use_rs || (bus.d_rs == '0)) hit_rs = 1'b0;
      if (!bus.d_use_rt || (bus.d_rt == '0)) hit_rt = 1'b0;
   end

   assign dstall_rs = hit_rs && (tn_rs > bus.d_tuse_rs);
   assign dstall_rt = hit_rt && (tn_rt > bus.d_tuse_rt);
   assign md_busy   = (cnt_q != '0);
   assign md_stall  = bus.d_md_acc && md_busy;
   assign stall     = bus.d_valid && (dstall_rs || dstall_rt || md_stall);

   assign bus.stall   = stall;
   assign bus.md_busy = md_busy;
   assign bus.fwd_rs  = (hit_rs && (tn_rs == '0)) ? idx_rs : '0;
   assign bus.fwd_rt  = (hit_rt && (tn_rt == '0)) ? idx_rt : '0;

   always_comb begin : entry_next
      wen_d  = '0;
      dst_d  = '0;
      tnew_d = '0;
      // A stalled decode slot enters E as a bubble.
      wen_d[1]  = !stall && bus.d_valid && bus.d_wen && (bus.d_wdst != '0);
      dst_d[1]  = stall ? '0 : bus.d_wdst;
      tnew_d[1] = stall ? '0 : bus.d_tnew;
      for (int k = 2; k <= NSTG; k++) begin
         wen_d[k]  = wen_q[k-1];
         dst_d[k]  = dst_q[k-1];
         tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
      end
   end

   // A start is only accepted when the slot actually issues; a stalled start is retried later.
   always_comb begin : busy_next
      if (bus.d_valid && bus.d_md_start && !stall) begin
         cnt_d = bus.d_md_op[1] ? CW'(DIV_LAT) : CW'(MUL_LAT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wen_q  <= '0;
         dst_q  <= '0;
         tnew_q <= '0;
         cnt_q  <= '0;
      end else begin
         wen_q  <= wen_d;
         dst_q  <= dst_d;
         tnew_q <= tnew_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
module tb_hazard_scoreboard;
   localparam int NSTG    = 3;
   localparam int AW      = 5;
   localparam int TW      = 2;
   localparam int SW      = 2;
   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.AW(AW), .TW(TW), .SW(SW)) bus ();

   hazard_scoreboard #(
      .NSTG(NSTG), .AW(AW), .TW(TW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CW(4), .SW(SW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       valid;
      logic [4:0] rs;
      logic       urs;
      logic [1:0] turs;
      logic [4:0] rt;
      logic       urt;
      logic [1:0] turt;
      logic       wen;
      logic [4:0] wdst;
      logic [1:0] tnew;
      logic       mds;
      logic [2:0] mdop;
      logic       mdacc;
      logic       e_stall;
      logic [1:0] e_frs;
      logic [1:0] e_frt;
      logic       e_busy;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic urs,
                               input logic [1:0] turs, input logic [4:0] rt, input logic urt,
                               input logic [1:0] turt, input logic wen, input logic [4:0] wdst,
                               input logic [1:0] tnew, input logic mds, input logic [2:0] mdop,
                               input logic mdacc, input logic es, input logic [1:0] efrs,
                               input logic [1:0] efrt, input logic eb);
      vec_t r;
      r.valid = v;   r.rs = rs;     r.urs = urs;   r.turs = turs;
      r.rt = rt;     r.urt = urt;   r.turt = turt; r.wen = wen;
      r.wdst = wdst; r.tnew = tnew; r.mds = mds;   r.mdop = mdop;
      r.mdacc = mdacc;
      r.e_stall = es; r.e_frs = efrs; r.e_frt = efrt; r.e_busy = eb;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.d_valid    = v.valid;
      bus.d_rs       = v.rs;
      bus.d_use_rs   = v.urs;
      bus.d_tuse_rs  = v.turs;
      bus.d_rt       = v.rt;
      bus.d_use_rt   = v.urt;
      bus.d_tuse_rt  = v.turt;
      bus.d_wen      = v.wen;
      bus.d_wdst     = v.wdst;
      bus.d_tnew     = v.tnew;
      bus.d_md_start = v.mds;
      bus.d_md_op    = v.mdop;
      bus.d_md_acc   = v.mdacc;
   endtask

   // Reference model: per-instruction issue records (youngest first) whose Tnew is derived
   // from age, and a multiply/divide "busy until cycle" mark.
   typedef struct {
      logic       wen;
      logic [4:0] dst;
      int         tnew0;
   } ent_t;

   ent_t pipe_q[$];
   int   cyc        = 0;
   int   busy_until = -1;

   function automatic void m_lookup(input logic use_s, input logic [4:0] s, input int tuse,
                                    output logic st, output int fwd);
      logic found;
      int   t;
      st    = 1'b0;
      fwd   = 0;
      found = 1'b0;
      if (use_s && (s != 5'd0)) begin
         for (int i = 0; i < pipe_q.size(); i++) begin
            if (!found && pipe_q[i].wen && (pipe_q[i].dst == s)) begin
               found = 1'b1;
               t     = pipe_q[i].tnew0 - i;
               if (t < 0) t = 0;
               st  = (t > tuse);
               fwd = (t == 0) ? i + 1 : 0;
            end
         end
      end
   endfunction

   task automatic m_eval(output logic st, output int frs, output int frt, output logic busy);
      logic sr, stt;
      busy = (cyc <= busy_until);
      m_lookup(bus.d_use_rs, bus.d_rs, int'(bus.d_tuse_rs), sr, frs);
      m_lookup(bus.d_use_rt, bus.d_rt, int'(bus.d_tuse_rt), stt, frt);
      st = bus.d_valid && (sr || stt || (bus.d_md_acc && busy));
   endtask

   task automatic tick(input logic st);
      ent_t e;
      e.wen   = !st && bus.d_valid && bus.d_wen && (bus.d_wdst != 5'd0);
      e.dst   = bus.d_wdst;
      e.tnew0 = int'(bus.d_tnew);
      pipe_q.push_front(e);
      if (pipe_q.size() > NSTG) void'(pipe_q.pop_back());
      if (bus.d_valid && bus.d_md_start && !st)
         busy_until = cyc + (bus.d_md_op[1] ? DIV_LAT : MUL_LAT);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic m_clear();
      pipe_q.delete();
      busy_until = -1;
   endtask

   task automatic apply_vec(input vec_t v, input string nm);
      logic ms, mb;
      int   mfr, mft;
      drive(v);
      #1;
      check({nm, ".stall"},   32'(bus.stall),   32'(v.e_stall));
      check({nm, ".fwd_rs"},  32'(bus.fwd_rs),  32'(v.e_frs));
      check({nm, ".fwd_rt"},  32'(bus.fwd_rt),  32'(v.e_frt));
      check({nm, ".md_busy"}, 32'(bus.md_busy), 32'(v.e_busy));
      m_eval(ms, mfr, mft, mb);
      tick(ms);
   endtask

   vec_t tbl[$];
   vec_t idle, mfhi_st, mfhi_ok, div_go, mul_go;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle    = mk(0, 0,0,0, 0,0,0, 0,0,0, 0,3'd0,0, 0,0,0,0);
      mfhi_st = mk(1, 0,0,0, 0,0,0, 1,2,1, 0,3'd0,1, 1,0,0,1);
      mfhi_ok = mk(1, 0,0,0, 0,0,0, 1,2,1, 0,3'd0,1, 0,0,0,0);
      div_go  = mk(1, 0,0,0, 0,0,0, 0,0,0, 1,3'b010,1, 0,0,0,0);
      mul_go  = mk(1, 0,0,0, 0,0,0, 0,0,0, 1,3'b000,1, 0,0,0,0);

      // Reset state, with an HI/LO accessor sitting in decode.
      reset = 1'b1;
      drive(mfhi_ok);
      #2;
      check("reset.stall",   32'(bus.stall),   32'd0);
      check("reset.md_busy", 32'(bus.md_busy), 32'd0);
      check("reset.fwd_rs",  32'(bus.fwd_rs),  32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_clear();

      // lw $8 (Tnew 2) then addu $9,$8,$8: two stall cycles, then forward from W.
      tbl.push_back(mk(1, 29,1,1, 0,0,0, 1,8,2, 0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 8,1,0, 8,1,0, 1,9,1, 0,0,0, 1,0,0,0));
      tbl.push_back(mk(1, 8,1,0, 8,1,0, 1,9,1, 0,0,0, 1,0,0,0));
      tbl.push_back(mk(1, 8,1,0, 8,1,0, 1,9,1, 0,0,0, 0,3,3,0));
      for (int i = 0; i < 3; i++) tbl.push_back(idle);
      // addu $8 then sw with $8 as rt (Tuse 1), then a Tuse 0 reader forwarding from M.
      tbl.push_back(mk(1, 1,1,0, 2,1,0, 1,8,1, 0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 29,1,1, 8,1,1, 0,0,0, 0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 8,1,0, 0,0,0, 0,0,0, 0,0,0, 0,2,0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(idle);
      // Two writes to $8; the younger one shadows the older one.
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,8,1, 0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,8,1, 0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 8,1,1, 8,1,1, 0,0,0, 0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 8,1,0, 8,1,0, 0,0,0, 0,0,0, 0,2,2,0));
      for (int i = 0; i < 3; i++) tbl.push_back(idle);
      // Write to $0 then read $0: never a hazard.
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,0,0, 0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 0,1,0, 0,1,0, 0,0,0, 0,0,0, 0,0,0,0));
      tbl.push_back(idle);
      // lw $5, an invalid slot that would hazard, then rt readers with Tuse 1.
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,5,2, 0,0,0, 0,0,0,0));
      tbl.push_back(mk(0, 5,1,0, 5,1,0, 0,0,0, 0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 3,1,0, 5,1,1, 0,0,0, 0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 3,1,0, 5,1,1, 0,0,0, 0,0,0, 0,0,3,0));
      for (int i = 0; i < 3; i++) tbl.push_back(idle);

      for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

      // div then mfhi: 10 stall cycles; a mult start on the drain cycle is accepted (5 more).
      apply_vec(div_go, "div_start");
      for (int j = 1; j <= DIV_LAT; j++) apply_vec(mfhi_st, $sformatf("div_wait%0d", j));
      apply_vec(mul_go, "mul_start");
      for (int j = 1; j <= MUL_LAT; j++) apply_vec(mfhi_st, $sformatf("mul_wait%0d", j));
      apply_vec(mfhi_ok, "mul_done");

      // Reset mid-divide (counter at 7) clears busy and stall without waiting for a clock.
      apply_vec(div_go, "rdiv_start");
      for (int j = 0; j < 3; j++)
         apply_vec(mk(0, 0,0,0, 0,0,0, 0,0,0, 0,3'd0,0, 0,0,0,1), $sformatf("rdiv_run%0d", j));
      drive(mfhi_ok);
      #1;
      check("rdiv_pre.stall", 32'(bus.stall), 32'd1);
      reset = 1'b1;
      #1;
      check("rdiv_async.stall",   32'(bus.stall),   32'd0);
      check("rdiv_async.md_busy", 32'(bus.md_busy), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_clear();
      apply_vec(mfhi_ok, "rdiv_mflo");

      // Randomised traffic against the reference model, with one reset in the middle.
      for (int n = 0; n < 400; n++) begin
         vec_t rv;
         logic ms, mb;
         int   mfr, mft;
         if (n == 200) begin
            reset = 1'b1;
            #2;
            @(posedge clk);
            #1;
            reset = 1'b0;
            m_clear();
         end
         rv       = idle;
         rv.valid = ($urandom_range(0, 9) != 0);
         rv.rs    = 5'($urandom_range(0, 3));
         rv.rt    = 5'($urandom_range(0, 3));
         rv.urs   = 1'($urandom_range(0, 1));
         rv.urt   = 1'($urandom_range(0, 1));
         rv.turs  = 2'($urandom_range(0, 3));
         rv.turt  = 2'($urandom_range(0, 3));
         rv.wen   = 1'($urandom_range(0, 1));
         rv.wdst  = 5'($urandom_range(0, 3));
         rv.tnew  = 2'($urandom_range(0, 3));
         rv.mds   = ($urandom_range(0, 19) == 0);
         rv.mdop  = 3'($urandom_range(0, 7));
         rv.mdacc = rv.mds || ($urandom_range(0, 3) == 0);
         drive(rv);
         #1;
         m_eval(ms, mfr, mft, mb);
         check($sformatf("rnd%0d.stall", n),   32'(bus.stall),   32'(ms));
         check($sformatf("rnd%0d.fwd_rs", n),  32'(bus.fwd_rs),  32'(mfr));
         check($sformatf("rnd%0d.fwd_rt", n),  32'(bus.fwd_rt),  32'(mft));
         check($sformatf("rnd%0d.md_busy", n), 32'(bus.md_busy), 32'(mb));
         tick(ms);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
